addsub_arbiter: RTL and testbench

- Shares one 32-bit add/sub datapath (operands A, B; SUB select; ans/cout/V outputs) between two requester ports.
- Arbitrates round-robin and drives the operands from registers.
- Waits a programmable number of settle cycles, because the gate-delay ripple adder needs up to about 100 ns to settle.
- Captures ans/cout/V and returns them to the granted requester through a valid/ready response handshake.

---
 rtl/addsub_arbiter_if.sv | 54 +++++
 rtl/addsub_arbiter.sv | 107 ++++++++++
 tb/tb_addsub_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/addsub_arbiter_if.sv
// Bundle of the two requester handshakes, the shared response channel and
// the connection to the external add/sub datapath.
//   req0_*/req1_* : operation request (valid/ready, operands, sub select)
//   rsp0_*/rsp1_* : response valid/ready per requester
//   rsp_ans/cout/v: captured result, shared by both response ports
//   au_*          : operands to and results from the ripple adder
// slave  = arbiter side, master = requester/datapath side.
interface addsub_arbiter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_sub;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_sub;
  logic             rsp0_valid;
  logic             rsp0_ready;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp_ans;
  logic             rsp_cout;
  logic             rsp_v;
  logic [WIDTH-1:0] au_a;
  logic [WIDTH-1:0] au_b;
  logic             au_sub;
  logic [WIDTH-1:0] au_ans;
  logic             au_cout;
  logic             au_v;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sub,
    input  req1_valid, req1_a, req1_b, req1_sub,
    input  rsp0_ready, rsp1_ready,
    input  au_ans, au_cout, au_v,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_ans, rsp_cout, rsp_v,
    output au_a, au_b, au_sub
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_sub,
    output req1_valid, req1_a, req1_b, req1_sub,
    output rsp0_ready, rsp1_ready,
    output au_ans, au_cout, au_v,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_ans, rsp_cout, rsp_v,
    input  au_a, au_b, au_sub
  );
endinterface

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one add/sub datapath between two requesters.
// Operands are registered onto au_*, held for SETTLE_CYC cycles while the
// ripple adder settles, then the result is captured and returned to the
// granted requester through a valid/ready response.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : requests, responses and datapath connection (slave modport)
//   busy  : high whenever not IDLE
module addsub_arbiter #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  addsub_arbiter_if.slave   bus,
  output logic              busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]       state;
  logic             ptr;
  logic             owner;
  logic [3:0]       cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sub_q;
  logic [WIDTH-1:0] ans_q;
  logic             cout_q;
  logic             v_q;
  logic             have;
  logic             win;
  logic             owner_ready;

  // Winner: a lone valid requester wins; on contention the pointer decides.
  always_comb begin
    have = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      win = ptr;
    end else begin
      win = bus.req1_valid;
    end
  end

  assign bus.req0_ready = (state == IDLE) && bus.req0_valid && !win;
  assign bus.req1_ready = (state == IDLE) && bus.req1_valid && win;

  assign bus.rsp0_valid = (state == RESP) && !owner;
  assign bus.rsp1_valid = (state == RESP) && owner;
  assign owner_ready    = owner ? bus.rsp1_ready : bus.rsp0_ready;

  assign bus.au_a     = a_q;
  assign bus.au_b     = b_q;
  assign bus.au_sub   = sub_q;
  assign bus.rsp_ans  = ans_q;
  assign bus.rsp_cout = cout_q;
  assign bus.rsp_v    = v_q;
  assign busy         = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= 1'b0;
      owner  <= 1'b0;
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      sub_q  <= 1'b0;
      ans_q  <= '0;
      cout_q <= 1'b0;
      v_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (have) begin
            a_q   <= win ? bus.req1_a   : bus.req0_a;
            b_q   <= win ? bus.req1_b   : bus.req0_b;
            sub_q <= win ? bus.req1_sub : bus.req0_sub;
            owner <= win;
            cnt   <= 4'(SETTLE_CYC - 1);
            state <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            ans_q  <= bus.au_ans;
            cout_q <= bus.au_cout;
            v_q    <= bus.au_v;
            state  <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (owner_ready) begin
            ptr   <= ~owner;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter: SETTLE_CYC=2 instance for the main
// sequence, SETTLE_CYC=1 instance with responses always accepted for the
// issue-interval checks. The datapath model returns corrupted results until
// its inputs have been stable long enough, so early capture is visible.
module tb_addsub_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  logic rst2_n;
  logic busy1;
  logic busy2;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  addsub_arbiter_if #(.WIDTH(32)) bus1 ();
  addsub_arbiter_if #(.WIDTH(32)) bus2 ();

  addsub_arbiter #(.WIDTH(32), .SETTLE_CYC(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus1),
    .busy (busy1)
  );

  addsub_arbiter #(.WIDTH(32), .SETTLE_CYC(1)) dut2 (
    .clk  (clk),
    .rst_n(rst2_n),
    .bus  (bus2),
    .busy (busy2)
  );

  // Datapath model for dut: valid only once inputs have been stable for
  // at least one full cycle before the capture cycle.
  logic [64:0] last1 = '0;
  logic [3:0]  stab  = '0;
  logic        changed1;
  logic [32:0] sum1;
  logic [31:0] bb1;
  logic        good1;

  always_comb begin
    changed1 = ({bus1.au_a, bus1.au_b, bus1.au_sub} != last1);
    bb1      = bus1.au_sub ? ~bus1.au_b : bus1.au_b;
    sum1     = {1'b0, bus1.au_a} + {1'b0, bb1} + {32'd0, bus1.au_sub};
    good1    = !changed1 && (stab >= 4'd1);
    bus1.au_ans  = good1 ? sum1[31:0] : ~sum1[31:0];
    bus1.au_cout = sum1[32] ^ !good1;
    bus1.au_v    = ((bus1.au_a[31] == bb1[31]) && (sum1[31] != bus1.au_a[31])) ^ !good1;
  end

  always @(posedge clk) begin
    last1 <= {bus1.au_a, bus1.au_b, bus1.au_sub};
    stab  <= changed1 ? 4'd1 : ((stab == 4'd15) ? stab : stab + 4'd1);
  end

  logic [32:0] sum2;
  assign sum2 = {1'b0, bus2.au_a} + {1'b0, bus2.au_sub ? ~bus2.au_b : bus2.au_b} + {32'd0, bus2.au_sub};
  assign bus2.au_ans  = sum2[31:0];
  assign bus2.au_cout = sum2[32];
  assign bus2.au_v    = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rv(input int p);
    return (p == 1) ? bus1.rsp1_valid : bus1.rsp0_valid;
  endfunction

  function automatic logic rdy(input int p);
    return (p == 1) ? bus1.req1_ready : bus1.req0_ready;
  endfunction

  task automatic set_req(input int p, input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic s);
    if (p == 0) begin
      bus1.req0_valid = v; bus1.req0_a = a; bus1.req0_b = b; bus1.req0_sub = s;
    end else begin
      bus1.req1_valid = v; bus1.req1_a = a; bus1.req1_b = b; bus1.req1_sub = s;
    end
  endtask

  task automatic set_rsp(input int p, input logic v);
    if (p == 0) bus1.rsp0_ready = v;
    else        bus1.rsp1_ready = v;
  endtask

  // Counts cycles from the first post-accept cycle until the response shows.
  task automatic wait_rsp(input int p, output int n);
    n = 1;
    while (!rv(p) && n < 20) begin
      cyc();
      n++;
    end
  endtask

  task automatic run_single(input int p, input logic [31:0] a, input logic [31:0] b, input logic s,
                            input logic [31:0] ea, input logic ec, input logic ev, input string tag);
    int n;
    set_req(p, 1'b1, a, b, s);
    #1;
    check({tag, "_ready"}, rdy(p), 1);
    check({tag, "_other_ready"}, rdy(1 - p), 0);
    cyc();
    set_req(p, 1'b0, a, b, s);
    #1;
    check({tag, "_busy"}, busy1, 1);
    check({tag, "_au_a"}, bus1.au_a, a);
    wait_rsp(p, n);
    check({tag, "_latency"}, n, 3);
    check({tag, "_other_valid"}, rv(1 - p), 0);
    check({tag, "_ans"}, bus1.rsp_ans, ea);
    check({tag, "_cout"}, bus1.rsp_cout, ec);
    check({tag, "_v"}, bus1.rsp_v, ev);
    set_rsp(p, 1'b1);
    cyc();
    set_rsp(p, 1'b0);
    #1;
    check({tag, "_valid_drop"}, rv(p), 0);
    check({tag, "_idle"}, busy1, 0);
  endtask

  logic [31:0] op_a [2][4];
  logic [31:0] op_b [2][4];
  logic        op_s [2][4];
  logic [31:0] ex_a [2][4];
  logic        ex_c [2][4];
  logic        ex_v [2][4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int g;
    int last;
    int n_acc;

    op_a[0][0] = 32'h7FFFFFFF; op_b[0][0] = 32'h00000001; op_s[0][0] = 1'b0;
    ex_a[0][0] = 32'h80000000; ex_c[0][0] = 1'b0;         ex_v[0][0] = 1'b1;
    op_a[0][1] = 32'h00000021; op_b[0][1] = 32'h00000022; op_s[0][1] = 1'b0;
    ex_a[0][1] = 32'h00000043; ex_c[0][1] = 1'b0;         ex_v[0][1] = 1'b0;
    op_a[0][2] = 32'h00000005; op_b[0][2] = 32'h00000007; op_s[0][2] = 1'b1;
    ex_a[0][2] = 32'hFFFFFFFE; ex_c[0][2] = 1'b0;         ex_v[0][2] = 1'b0;
    op_a[0][3] = 32'hFFFFFFFF; op_b[0][3] = 32'h00000001; op_s[0][3] = 1'b0;
    ex_a[0][3] = 32'h00000000; ex_c[0][3] = 1'b1;         ex_v[0][3] = 1'b0;
    op_a[1][0] = 32'h336FB7E5; op_b[1][0] = 32'h336FB7E5; op_s[1][0] = 1'b1;
    ex_a[1][0] = 32'h00000000; ex_c[1][0] = 1'b1;         ex_v[1][0] = 1'b0;
    op_a[1][1] = 32'h80000000; op_b[1][1] = 32'h00000001; op_s[1][1] = 1'b1;
    ex_a[1][1] = 32'h7FFFFFFF; ex_c[1][1] = 1'b1;         ex_v[1][1] = 1'b1;
    op_a[1][2] = 32'h80000000; op_b[1][2] = 32'h80000000; op_s[1][2] = 1'b0;
    ex_a[1][2] = 32'h00000000; ex_c[1][2] = 1'b1;         ex_v[1][2] = 1'b1;
    op_a[1][3] = 32'h00000010; op_b[1][3] = 32'h00000003; op_s[1][3] = 1'b1;
    ex_a[1][3] = 32'h0000000D; ex_c[1][3] = 1'b1;         ex_v[1][3] = 1'b0;

    rst_n  = 1'b0;
    rst2_n = 1'b0;
    set_req(0, 1'b0, '0, '0, 1'b0);
    set_req(1, 1'b0, '0, '0, 1'b0);
    bus1.rsp0_ready = 1'b0;
    bus1.rsp1_ready = 1'b0;
    bus2.req0_valid = 1'b0; bus2.req0_a = '0; bus2.req0_b = '0; bus2.req0_sub = 1'b0;
    bus2.req1_valid = 1'b0; bus2.req1_a = '0; bus2.req1_b = '0; bus2.req1_sub = 1'b0;
    bus2.rsp0_ready = 1'b1;
    bus2.rsp1_ready = 1'b1;
    repeat (2) cyc();

    // Reset state
    check("rst_au_a", bus1.au_a, 0);
    check("rst_au_b", bus1.au_b, 0);
    check("rst_au_sub", bus1.au_sub, 0);
    check("rst_ans", bus1.rsp_ans, 0);
    check("rst_cout", bus1.rsp_cout, 0);
    check("rst_v", bus1.rsp_v, 0);
    check("rst_rsp0_valid", bus1.rsp0_valid, 0);
    check("rst_rsp1_valid", bus1.rsp1_valid, 0);
    check("rst_busy", busy1, 0);
    rst_n = 1'b1;
    cyc();

    // Single requests on each port
    run_single(0, 32'h00000021, 32'h00000022, 1'b0, 32'h00000043, 1'b0, 1'b0, "t1");
    run_single(1, 32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, "t2");

    // Fresh reset, then both requesters valid continuously: grants alternate from 0
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    for (int k = 0; k < 8; k++) begin
      int i0;
      int i1;
      int idx;
      g   = k % 2;
      i0  = ((k + 1) / 2) % 4;
      i1  = k / 2;
      idx = k / 2;
      set_req(0, 1'b1, op_a[0][i0], op_b[0][i0], op_s[0][i0]);
      set_req(1, 1'b1, op_a[1][i1], op_b[1][i1], op_s[1][i1]);
      #1;
      check("rr_grant", rdy(g), 1);
      check("rr_other_ready", rdy(1 - g), 0);
      cyc();
      wait_rsp(g, n);
      check("rr_latency", n, 3);
      check("rr_other_valid", rv(1 - g), 0);
      check("rr_ans", bus1.rsp_ans, ex_a[g][idx]);
      check("rr_cout", bus1.rsp_cout, ex_c[g][idx]);
      check("rr_v", bus1.rsp_v, ex_v[g][idx]);
      set_rsp(g, 1'b1);
      cyc();
      set_rsp(g, 1'b0);
    end
    set_req(0, 1'b0, '0, '0, 1'b0);
    set_req(1, 1'b0, '0, '0, 1'b0);
    #1;

    // Backpressure on rsp0 while requester 1 waits
    set_req(0, 1'b1, 32'h0000FFFF, 32'h00000001, 1'b0);
    #1;
    check("bp_ready0", bus1.req0_ready, 1);
    cyc();
    set_req(0, 1'b0, 32'h0000FFFF, 32'h00000001, 1'b0);
    set_req(1, 1'b1, 32'h12345678, 32'h02345678, 1'b1);
    #1;
    wait_rsp(0, n);
    check("bp_latency", n, 3);
    for (int k = 0; k < 5; k++) begin
      check("bp_valid_hold", bus1.rsp0_valid, 1);
      check("bp_ans_hold", bus1.rsp_ans, 32'h00010000);
      check("bp_au_a_hold", bus1.au_a, 32'h0000FFFF);
      check("bp_au_b_hold", bus1.au_b, 32'h00000001);
      check("bp_req1_stall", bus1.req1_ready, 0);
      cyc();
    end
    bus1.rsp1_ready = 1'b1;
    bus1.rsp0_ready = 1'b1;
    #1;
    check("bp_req1_stall_last", bus1.req1_ready, 0);
    cyc();
    bus1.rsp0_ready = 1'b0;
    #1;
    check("bp_valid_drop", bus1.rsp0_valid, 0);
    check("bp_req1_granted", bus1.req1_ready, 1);
    cyc();
    set_req(1, 1'b0, 32'h12345678, 32'h02345678, 1'b1);
    #1;
    wait_rsp(1, n);
    check("bp1_latency", n, 3);
    check("bp1_ans", bus1.rsp_ans, 32'h10000000);
    check("bp1_cout", bus1.rsp_cout, 1);
    check("bp1_v", bus1.rsp_v, 0);
    cyc();
    check("bp1_resp_one_cycle", bus1.rsp1_valid, 0);
    check("bp1_idle", busy1, 0);
    bus1.rsp1_ready = 1'b0;

    // Reset during SETTLE with the pointer favouring requester 1
    run_single(0, 32'h00000021, 32'h00000022, 1'b0, 32'h00000043, 1'b0, 1'b0, "t5a");
    set_req(1, 1'b1, 32'hAAAA5555, 32'h11111111, 1'b0);
    #1;
    check("mr_ready1", bus1.req1_ready, 1);
    cyc();
    set_req(1, 1'b0, 32'hAAAA5555, 32'h11111111, 1'b0);
    #1;
    check("mr_in_settle", busy1, 1);
    rst_n = 1'b0;
    #1;
    check("mr_au_a", bus1.au_a, 0);
    check("mr_au_b", bus1.au_b, 0);
    check("mr_ans", bus1.rsp_ans, 0);
    check("mr_busy", busy1, 0);
    check("mr_valids", {bus1.rsp0_valid, bus1.rsp1_valid}, 0);
    cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      check("mr_no_rsp", {bus1.rsp0_valid, bus1.rsp1_valid}, 0);
    end
    set_req(0, 1'b1, 32'h1, 32'h1, 1'b0);
    set_req(1, 1'b1, 32'h2, 32'h2, 1'b0);
    #1;
    check("mr_ptr_ready0", bus1.req0_ready, 1);
    check("mr_ptr_ready1", bus1.req1_ready, 0);
    set_req(0, 1'b0, 32'h1, 32'h1, 1'b0);
    set_req(1, 1'b0, 32'h2, 32'h2, 1'b0);

    // SETTLE_CYC=1, responses always accepted: accepts every 3 cycles
    bus2.req0_valid = 1'b1;
    bus2.req0_a     = 32'h00000001;
    bus2.req0_b     = 32'h00000002;
    cyc();
    rst2_n = 1'b1;
    #1;
    last  = -1;
    n_acc = 0;
    for (int c = 0; c < 12; c++) begin
      check("s1_busy", busy2, !bus2.req0_ready);
      if (bus2.req0_ready) begin
        if (last >= 0) check("s1_interval", c - last, 3);
        last = c;
        n_acc++;
      end
      if (bus2.rsp0_valid) check("s1_ans", bus2.rsp_ans, 32'h00000003);
      cyc();
    end
    check("s1_accepts", n_acc, 4);
    bus2.req0_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
